// File: rtl/fma_pkg.sv
// fma_pkg: shared encodings and helpers for the FMA issue controller.
`default_nettype none

package fma_pkg;

  localparam int RM_W = 3;

  localparam logic [RM_W-1:0] RM_RNE = 3'b000;
  localparam logic [RM_W-1:0] RM_RTZ = 3'b001;
  localparam logic [RM_W-1:0] RM_RDN = 3'b010;
  localparam logic [RM_W-1:0] RM_RUP = 3'b011;
  localparam logic [RM_W-1:0] RM_RMM = 3'b100;
  localparam logic [RM_W-1:0] RM_DYN = 3'b111;

  typedef enum logic [1:0] {
    OP_FMADD  = 2'b00,
    OP_FMSUB  = 2'b01,
    OP_FNMSUB = 2'b10,
    OP_FNMADD = 2'b11
  } fma_op_e;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Only the five IEEE modes RNE..RMM are usable once DYN has been resolved.
  function automatic logic rm_is_legal(input logic [RM_W-1:0] rm);
    return (rm <= RM_RMM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fma_issue_ctrl_if.sv
// fma_issue_ctrl_if: decode request and writeback handshake bundle.
`default_nettype none

interface fma_issue_ctrl_if #(
  parameter int PARM_TAG = 5,
  parameter int PARM_RM  = 3
);
  logic                req_valid_i;
  logic                req_ready_o;
  logic [1:0]          req_op_i;
  logic [PARM_RM-1:0]  req_rm_i;
  logic [PARM_TAG-1:0] req_tag_i;

  logic                wb_valid_o;
  logic                wb_ready_i;
  logic [PARM_TAG-1:0] wb_tag_o;
  logic [4:0]          wb_flags_o;

  modport master (
    output req_valid_i, req_op_i, req_rm_i, req_tag_i, wb_ready_i,
    input  req_ready_o, wb_valid_o, wb_tag_o, wb_flags_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_rm_i, req_tag_i, wb_ready_i,
    output req_ready_o, wb_valid_o, wb_tag_o, wb_flags_o
  );
endinterface

`default_nettype wire

// File: rtl/fma_ctrl_slot.sv
// fma_ctrl_slot: one pipeline stage of control state (valid/tag/rm/op).
`default_nettype none

module fma_ctrl_slot #(
  parameter int PARM_TAG = 5,
  parameter int PARM_RM  = 3
) (
  input  wire logic                clk_i,
  input  wire logic                rst_i,
  input  wire logic                load_i,
  input  wire logic                clr_i,
  input  wire logic [PARM_TAG-1:0] d_tag_i,
  input  wire logic [PARM_RM-1:0]  d_rm_i,
  input  wire logic [1:0]          d_op_i,
  output logic                     valid_o,
  output logic [PARM_TAG-1:0]      tag_o,
  output logic [PARM_RM-1:0]       rm_o,
  output logic [1:0]               op_o
);

  logic                r_valid;
  logic [PARM_TAG-1:0] r_tag;
  logic [PARM_RM-1:0]  r_rm;
  logic [1:0]          r_op;

  // Clearing drops only the valid bit; payload is retained so outputs stay quiet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_rm    <= '0;
      r_op    <= '0;
    end else if (load_i) begin
      r_valid <= 1'b1;
      r_tag   <= d_tag_i;
      r_rm    <= d_rm_i;
      r_op    <= d_op_i;
    end else if (clr_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o = r_valid;
  assign tag_o   = r_tag;
  assign rm_o    = r_rm;
  assign op_o    = r_op;

endmodule

`default_nettype wire

// File: rtl/fma_issue_ctrl.sv
// fma_issue_ctrl: FMA request sequencing, stage enables, writeback and fflags.
`default_nettype none

module fma_issue_ctrl
  import fma_pkg::*;
#(
  parameter int                 PARM_STAGES = 3,
  parameter int                 PARM_TAG    = 5,
  parameter int                 PARM_RM     = 3,
  parameter logic [PARM_RM-1:0] PARM_RM_DYN = 3'b111
) (
  input  wire logic                   clk_i,
  input  wire logic                   rst_i,
  fma_issue_ctrl_if.slave             bus,
  input  wire logic [PARM_RM-1:0]     frm_i,
  input  wire logic                   flush_i,
  output logic                        illegal_o,
  output logic [PARM_STAGES-1:0]      dp_stage_en_o,
  output logic                        dp_sub_o,
  output logic                        dp_neg_o,
  output logic [PARM_RM-1:0]          dp_rm_o,
  input  wire logic                   dp_invalid_i,
  input  wire logic                   dp_overflow_i,
  input  wire logic                   dp_underflow_i,
  input  wire logic                   dp_inexact_i,
  input  wire logic                   fflags_clr_i,
  output logic [4:0]                  fflags_o,
  output logic                        busy_o
);

  localparam int LAST = PARM_STAGES - 1;

  logic [PARM_STAGES-1:0] w_valid;
  logic [PARM_STAGES-1:0] w_adv;
  logic [PARM_STAGES-1:0] w_en;
  logic [PARM_STAGES-1:0] w_clr;
  logic [PARM_TAG-1:0]    w_tag [PARM_STAGES];
  logic [PARM_RM-1:0]     w_rm  [PARM_STAGES];
  logic [1:0]             w_op  [PARM_STAGES];

  logic [PARM_RM-1:0] w_rm_res;
  logic               w_legal;
  logic               w_accept;
  logic               w_hs;
  logic [4:0]         w_wb_flags;
  logic               w_unused;

  logic [4:0] r_fflags;
  logic       r_illegal;

  // A stage can move when it is empty or its successor moves, so bubbles collapse.
  assign w_adv[LAST] = ~w_valid[LAST] | bus.wb_ready_i;

  generate
    for (genvar i = 0; i < LAST; i++) begin : g_adv
      assign w_adv[i] = ~w_valid[i] | w_adv[i+1];
    end
  endgenerate

  assign w_rm_res        = (bus.req_rm_i == PARM_RM_DYN) ? frm_i : bus.req_rm_i;
  assign w_legal         = rm_is_legal(w_rm_res);
  assign bus.req_ready_o = w_adv[0] & ~flush_i;
  assign w_accept        = bus.req_valid_i & bus.req_ready_o;

  assign w_en[0] = w_accept & w_legal;

  generate
    for (genvar i = 1; i < PARM_STAGES; i++) begin : g_en
      assign w_en[i] = w_valid[i-1] & w_adv[i] & ~flush_i;
    end
  endgenerate

  generate
    for (genvar i = 0; i < PARM_STAGES; i++) begin : g_slot
      // A stage that moves on without being refilled becomes a bubble.
      assign w_clr[i] = flush_i | w_adv[i];

      if (i == 0) begin : g_head
        fma_ctrl_slot #(
          .PARM_TAG (PARM_TAG),
          .PARM_RM  (PARM_RM)
        ) u_slot (
          .clk_i   (clk_i),
          .rst_i   (rst_i),
          .load_i  (w_en[i]),
          .clr_i   (w_clr[i]),
          .d_tag_i (bus.req_tag_i),
          .d_rm_i  (w_rm_res),
          .d_op_i  (bus.req_op_i),
          .valid_o (w_valid[i]),
          .tag_o   (w_tag[i]),
          .rm_o    (w_rm[i]),
          .op_o    (w_op[i])
        );
      end else begin : g_body
        fma_ctrl_slot #(
          .PARM_TAG (PARM_TAG),
          .PARM_RM  (PARM_RM)
        ) u_slot (
          .clk_i   (clk_i),
          .rst_i   (rst_i),
          .load_i  (w_en[i]),
          .clr_i   (w_clr[i]),
          .d_tag_i (w_tag[i-1]),
          .d_rm_i  (w_rm[i-1]),
          .d_op_i  (w_op[i-1]),
          .valid_o (w_valid[i]),
          .tag_o   (w_tag[i]),
          .rm_o    (w_rm[i]),
          .op_o    (w_op[i])
        );
      end
    end
  endgenerate

  always_comb begin
    w_wb_flags = '0;
    if (w_valid[LAST]) begin
      w_wb_flags[FLAG_NV] = dp_invalid_i;
      w_wb_flags[FLAG_DZ] = 1'b0;
      w_wb_flags[FLAG_OF] = dp_overflow_i;
      w_wb_flags[FLAG_UF] = dp_underflow_i;
      w_wb_flags[FLAG_NX] = dp_inexact_i;
    end
  end

  // A flush kills the result on the bus, so it is not counted as written back.
  assign w_hs = w_valid[LAST] & bus.wb_ready_i & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fflags  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept & ~w_legal;
      if (fflags_clr_i) begin
        r_fflags <= w_hs ? w_wb_flags : 5'b0;
      end else if (w_hs) begin
        r_fflags <= r_fflags | w_wb_flags;
      end
    end
  end

  assign bus.wb_valid_o = w_valid[LAST];
  assign bus.wb_tag_o   = w_tag[LAST];
  assign bus.wb_flags_o = w_wb_flags;
  assign dp_rm_o        = w_rm[LAST];
  assign dp_sub_o       = w_op[0][0];
  assign dp_neg_o       = w_op[0][1];
  assign dp_stage_en_o  = w_en;
  assign illegal_o      = r_illegal;
  assign fflags_o       = r_fflags;
  assign busy_o         = |w_valid;

  assign w_unused = ^w_op[LAST];

endmodule

`default_nettype wire

// File: tb/tb_fma_issue_ctrl.sv
// tb_fma_issue_ctrl: directed vector table plus hand sequences for stall/flags/flush/reset.
`default_nettype none

module tb_fma_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] frm;
  logic       flush;
  logic       illegal;
  logic [2:0] stage_en;
  logic       dp_sub, dp_neg;
  logic [2:0] dp_rm;
  logic       dp_inv, dp_of, dp_uf, dp_nx;
  logic       fclr;
  logic [4:0] fflags;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  fma_issue_ctrl_if #(.PARM_TAG(5), .PARM_RM(3)) bus ();

  fma_issue_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .frm_i          (frm),
    .flush_i        (flush),
    .illegal_o      (illegal),
    .dp_stage_en_o  (stage_en),
    .dp_sub_o       (dp_sub),
    .dp_neg_o       (dp_neg),
    .dp_rm_o        (dp_rm),
    .dp_invalid_i   (dp_inv),
    .dp_overflow_i  (dp_of),
    .dp_underflow_i (dp_uf),
    .dp_inexact_i   (dp_nx),
    .fflags_clr_i   (fclr),
    .fflags_o       (fflags),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rv;
    logic [1:0] op;
    logic [2:0] rm;
    logic [4:0] tag;
    logic [2:0] frm;
    logic       rdy;
    logic [2:0] en;
    logic       wbv;
    logic [4:0] wtag;
    logic [2:0] drm;
    logic       ill;
    logic       busy;
    logic       sub;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = 2'b00;
    bus.req_rm_i    = 3'b000;
    bus.req_tag_i   = 5'd0;
    bus.wb_ready_i  = 1'b1;
    frm   = 3'b000;
    flush = 1'b0;
    fclr  = 1'b0;
    {dp_inv, dp_of, dp_uf, dp_nx} = 4'b0000;
  endtask

  // Issue one legal op, then complete its writeback with the given {NV,OF,UF,NX} and clear.
  task automatic one_op(input logic [4:0] t, input logic [3:0] fl, input logic clr);
    int n;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1; bus.req_rm_i = 3'b000; bus.req_tag_i = t; bus.wb_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    n = 0;
    while (!bus.wb_valid_o && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("op.wb_timeout", {31'd0, bus.wb_valid_o}, 32'd1);
    {dp_inv, dp_of, dp_uf, dp_nx} = fl;
    fclr = clr;
    #1;
    chk("op.wb_tag", {27'd0, bus.wb_tag_o}, {27'd0, t});
    chk("op.wb_flags", {27'd0, bus.wb_flags_o}, {27'd0, fl[3], 1'b0, fl[2:0]});
    @(posedge clk); #1;
    {dp_inv, dp_of, dp_uf, dp_nx} = 4'b0000;
    fclr = 1'b0;
  endtask

  initial begin
    logic [4:0] got[$];
    int         sent;

    //          rv op     rm      tag    frm     rdy en      wbv wtag   drm     ill  busy sub
    tbl.push_back('{1, 2'd0, 3'd0, 5'd5, 3'd0, 1, 3'b001, 0, 5'd0, 3'd0, 0, 0, 0});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b010, 0, 5'd0, 3'd0, 0, 1, 0});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b100, 0, 5'd0, 3'd0, 0, 1, 0});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b000, 1, 5'd5, 3'd0, 0, 1, 0});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b000, 0, 5'd5, 3'd0, 0, 0, 0});
    tbl.push_back('{1, 2'd1, 3'd7, 5'd9, 3'd3, 1, 3'b001, 0, 5'd5, 3'd0, 0, 0, 0});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b010, 0, 5'd5, 3'd0, 0, 1, 1});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b100, 0, 5'd5, 3'd0, 0, 1, 1});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b000, 1, 5'd9, 3'd3, 0, 1, 1});
    tbl.push_back('{1, 2'd0, 3'd5, 5'd7, 3'd3, 1, 3'b000, 0, 5'd9, 3'd3, 0, 0, 1});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b000, 0, 5'd9, 3'd3, 1, 0, 1});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b000, 0, 5'd9, 3'd3, 0, 0, 1});
    tbl.push_back('{1, 2'd0, 3'd7, 5'd6, 3'd6, 1, 3'b000, 0, 5'd9, 3'd3, 0, 0, 1});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b000, 0, 5'd9, 3'd3, 1, 0, 1});
    tbl.push_back('{1, 2'd2, 3'd4, 5'd3, 3'd6, 1, 3'b001, 0, 5'd9, 3'd3, 0, 0, 1});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b010, 0, 5'd9, 3'd3, 0, 1, 0});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b100, 0, 5'd9, 3'd3, 0, 1, 0});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b000, 1, 5'd3, 3'd4, 0, 1, 0});
    tbl.push_back('{0, 2'd0, 3'd0, 5'd0, 3'd0, 1, 3'b000, 0, 5'd3, 3'd4, 0, 0, 0});

    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.wbv", {31'd0, bus.wb_valid_o}, 32'd0);
    chk("rst.fflags", {27'd0, fflags}, 32'd0);
    chk("rst.en", {29'd0, stage_en}, 32'd0);
    chk("rst.ill", {31'd0, illegal}, 32'd0);
    chk("rst.tag_rm", {24'd0, bus.wb_tag_o, dp_rm}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive_idle();
      bus.req_valid_i = tbl[i].rv;
      bus.req_op_i    = tbl[i].op;
      bus.req_rm_i    = tbl[i].rm;
      bus.req_tag_i   = tbl[i].tag;
      frm             = tbl[i].frm;
      @(negedge clk);
      chk($sformatf("v%0d.rdy", i),  {31'd0, bus.req_ready_o}, {31'd0, tbl[i].rdy});
      chk($sformatf("v%0d.en", i),   {29'd0, stage_en},        {29'd0, tbl[i].en});
      chk($sformatf("v%0d.wbv", i),  {31'd0, bus.wb_valid_o},  {31'd0, tbl[i].wbv});
      chk($sformatf("v%0d.wtag", i), {27'd0, bus.wb_tag_o},    {27'd0, tbl[i].wtag});
      chk($sformatf("v%0d.drm", i),  {29'd0, dp_rm},           {29'd0, tbl[i].drm});
      chk($sformatf("v%0d.ill", i),  {31'd0, illegal},         {31'd0, tbl[i].ill});
      chk($sformatf("v%0d.busy", i), {31'd0, busy},            {31'd0, tbl[i].busy});
      chk($sformatf("v%0d.sub", i),  {31'd0, dp_sub},          {31'd0, tbl[i].sub});
    end
    @(posedge clk); #1;
    drive_idle();

    // Four back-to-back ops, writeback stalled for two cycles after the first result.
    sent = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      bus.req_valid_i = (sent <= 4);
      bus.req_tag_i   = 5'(sent);
      bus.req_rm_i    = 3'b000;
      bus.wb_ready_i  = !(c == 3 || c == 4);
      @(negedge clk);
      if (c <= 5)
        chk("stall.rdy", {31'd0, bus.req_ready_o}, (c == 3 || c == 4) ? 32'd0 : 32'd1);
      if (c == 3 || c == 4) begin
        chk("stall.wbv", {31'd0, bus.wb_valid_o}, 32'd1);
        chk("stall.tag", {27'd0, bus.wb_tag_o}, 32'd1);
      end
      if (bus.req_valid_i && bus.req_ready_o) sent++;
      if (bus.wb_valid_o && bus.wb_ready_i) got.push_back(bus.wb_tag_o);
    end
    @(posedge clk); #1;
    drive_idle();
    chk("stall.count", got.size(), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk($sformatf("stall.order%0d", i), {27'd0, got[i]}, i + 1);

    // Flag accumulation and clear-with-handshake.
    one_op(5'd21, 4'b0001, 1'b0);
    chk("flags.nx", {27'd0, fflags}, 32'h01);
    one_op(5'd22, 4'b0100, 1'b0);
    chk("flags.of_nx", {27'd0, fflags}, 32'h05);
    one_op(5'd23, 4'b1000, 1'b1);
    chk("flags.clr_nv", {27'd0, fflags}, 32'h10);

    // Fill all three stages, then flush with a request pending and a result on the bus.
    @(posedge clk); #1;
    bus.wb_ready_i = 1'b0; bus.req_valid_i = 1'b1; bus.req_tag_i = 5'd10;
    @(posedge clk); #1;
    bus.req_tag_i = 5'd11;
    @(posedge clk); #1;
    bus.req_tag_i = 5'd12;
    @(posedge clk); #1;
    bus.req_tag_i = 5'd13; flush = 1'b1; bus.wb_ready_i = 1'b1; dp_of = 1'b1;
    #1;
    chk("flush.rdy", {31'd0, bus.req_ready_o}, 32'd0);
    chk("flush.en", {29'd0, stage_en}, 32'd0);
    chk("flush.full", {31'd0, busy & bus.wb_valid_o}, 32'd1);
    @(posedge clk); #1;
    drive_idle();
    chk("flush.busy", {31'd0, busy}, 32'd0);
    chk("flush.wbv", {31'd0, bus.wb_valid_o}, 32'd0);
    chk("flush.fflags", {27'd0, fflags}, 32'h10);
    chk("flush.ill", {31'd0, illegal}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("flush.no_wb", {31'd0, bus.wb_valid_o}, 32'd0);
    end

    // Clear alone, then reset with two ops in flight and fflags=00011.
    @(posedge clk); #1;
    fclr = 1'b1;
    @(posedge clk); #1;
    fclr = 1'b0;
    chk("clr.alone", {27'd0, fflags}, 32'd0);
    one_op(5'd24, 4'b0011, 1'b0);
    chk("rst2.pre_fflags", {27'd0, fflags}, 32'h03);
    @(posedge clk); #1;
    bus.wb_ready_i = 1'b0; bus.req_valid_i = 1'b1; bus.req_tag_i = 5'd20; bus.req_rm_i = 3'b011;
    @(posedge clk); #1;
    bus.req_tag_i = 5'd21;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    chk("rst2.busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.wb_ready_i = 1'b1;
    chk("rst2.fflags", {27'd0, fflags}, 32'd0);
    chk("rst2.busy", {31'd0, busy}, 32'd0);
    chk("rst2.wbv", {31'd0, bus.wb_valid_o}, 32'd0);
    chk("rst2.tag", {27'd0, bus.wb_tag_o}, 32'd0);
    chk("rst2.en", {29'd0, stage_en}, 32'd0);
    chk("rst2.ill", {31'd0, illegal}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("rst2.no_wb", {31'd0, bus.wb_valid_o}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
